// File: rtl/pdp8_pkg.sv
// ---------------------------------------------------------------------------
// pdp8_pkg
// Shared types for the PDP-8 decode/execute interface.
//   pdp_mem_opcode_s  : memory-reference opcode (6 one-hot flags + 12-bit addr)
//   pdp_op7_opcode_s  : group-7 operate opcode (22 one-hot flags, NOP at MSB)
//   exec_resp_state_e : state encoding of the execution-unit stand-in
// The width and start-address macros are global so every file that includes
// this package sees the same machine geometry.
// ---------------------------------------------------------------------------
`ifndef PDP8_PKG_DEFINES
`define PDP8_PKG_DEFINES
`define ADDR_WIDTH 12
`define DATA_WIDTH 12
`define START_ADDRESS 12'o0200
`endif

package pdp8_pkg;

   typedef struct packed {
      logic                     AND;
      logic                     TAD;
      logic                     ISZ;
      logic                     DCA;
      logic                     JMS;
      logic                     JMP;
      logic [`ADDR_WIDTH-1:0]   mem_inst_addr;
   } pdp_mem_opcode_s;

   typedef struct packed {
      logic NOP;
      logic IAC;
      logic RAL;
      logic RTL;
      logic RAR;
      logic RTR;
      logic CML;
      logic CMA;
      logic CIA;
      logic CLL;
      logic CLA1;
      logic CLA_CLL;
      logic HLT;
      logic OSR;
      logic SKP;
      logic SNL;
      logic SZL;
      logic SZA;
      logic SNA;
      logic SMA;
      logic SPA;
      logic CLA2;
   } pdp_op7_opcode_s;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      EXEC = 2'd2
   } exec_resp_state_e;

   // True when more than one memory-reference flag is set. Clearing the
   // lowest set bit leaves something only if a second bit was also set.
   function automatic logic mem_flags_multi(input pdp_mem_opcode_s m);
      logic [5:0] flags;
      flags = {m.AND, m.TAD, m.ISZ, m.DCA, m.JMS, m.JMP};
      return (flags & (flags - 6'd1)) != 6'd0;
   endfunction

endpackage

// File: rtl/pc_next_calc.sv
// ---------------------------------------------------------------------------
// pc_next_calc
// Combinational next-PC selection for the instruction currently executing.
//   i_pc       : current program counter
//   i_mem      : latched memory-reference opcode
//   i_isz_skip : latched ISZ skip control
//   i_illegal  : latched illegal flag; illegal opcodes behave as a NOP
//   o_next_pc  : PC value to load when execution completes
// All arithmetic wraps modulo 2^ADDR_WIDTH through natural truncation.
// ---------------------------------------------------------------------------
module pc_next_calc
   import pdp8_pkg::*;
(
   input  logic [`ADDR_WIDTH-1:0] i_pc,
   input  pdp_mem_opcode_s        i_mem,
   input  logic                   i_isz_skip,
   input  logic                   i_illegal,
   output logic [`ADDR_WIDTH-1:0] o_next_pc
);

   localparam int AW = `ADDR_WIDTH;

   // Default is a sequential step; op7 opcodes, AND/TAD/DCA and illegal
   // opcodes all take it. Only legal JMP/JMS/ISZ-with-skip redirect.
   always_comb begin
      o_next_pc = i_pc + AW'(1);
      if (!i_illegal) begin
         if (i_mem.JMP) begin
            o_next_pc = i_mem.mem_inst_addr;
         end else if (i_mem.JMS) begin
            o_next_pc = i_mem.mem_inst_addr + AW'(1);
         end else if (i_mem.ISZ && i_isz_skip) begin
            o_next_pc = i_pc + AW'(2);
         end
      end
   end

endmodule

// File: rtl/instr_exec_responder.sv
// ---------------------------------------------------------------------------
// instr_exec_responder
// Stand-in for the PDP-8 execution unit used when verifying fetch/decode.
// Accepts decode-to-exec opcodes, holds stall for an opcode-dependent
// latency, maintains the program counter and counts executed and illegal
// instructions.
//   clk, reset      : clock and asynchronous active-high reset
//   base_addr       : start PC, loaded on the first clock after reset
//   pdp_mem_opcode  : memory-reference opcode from decode
//   pdp_op7_opcode  : group-7 operate opcode from decode
//   isz_skip        : when high at ISZ acceptance, the ISZ skips
//   stall           : decode must hold its opcodes while high
//   PC_value        : current program counter
//   instr_cnt       : accepted non-zero opcodes
//   err_cnt         : accepted illegal opcodes (saturating)
// ---------------------------------------------------------------------------
module instr_exec_responder
   import pdp8_pkg::*;
#(
   parameter int MEM_LAT    = 4,
   parameter int OP7_LAT    = 2,
   parameter int INIT_STALL = 2
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [`ADDR_WIDTH-1:0] base_addr,
   input  pdp_mem_opcode_s        pdp_mem_opcode,
   input  pdp_op7_opcode_s        pdp_op7_opcode,
   input  logic                   isz_skip,
   output logic                   stall,
   output logic [`ADDR_WIDTH-1:0] PC_value,
   output logic [31:0]            instr_cnt,
   output logic [15:0]            err_cnt
);

   localparam int AW = `ADDR_WIDTH;
   localparam int CW = 16;

   exec_resp_state_e r_state;
   logic [CW-1:0]    r_lat_cnt;
   logic             r_stall;
   logic [AW-1:0]    r_pc;
   logic [31:0]      r_instr_cnt;
   logic [15:0]      r_err_cnt;
   pdp_mem_opcode_s  r_mem;
   logic             r_isz_skip;
   logic             r_illegal;

   logic             w_mem_active;
   logic             w_op7_active;
   logic             w_bubble;
   logic             w_illegal;
   logic [CW-1:0]    w_lat;
   logic [AW-1:0]    w_next_pc;

   // Opcode classification of whatever decode is presenting right now.
   // An illegal opcode runs as a NOP, so it takes the op7 latency even if
   // memory-reference flags are set.
   assign w_mem_active = |pdp_mem_opcode;
   assign w_op7_active = |pdp_op7_opcode;
   assign w_bubble     = !w_mem_active && !w_op7_active;
   assign w_illegal    = mem_flags_multi(pdp_mem_opcode) || (w_mem_active && w_op7_active);
   assign w_lat        = (w_mem_active && !w_illegal) ? CW'(MEM_LAT) : CW'(OP7_LAT);

   pc_next_calc u_pc_next_calc (
      .i_pc       (r_pc),
      .i_mem      (r_mem),
      .i_isz_skip (r_isz_skip),
      .i_illegal  (r_illegal),
      .o_next_pc  (w_next_pc)
   );

   // Main FSM. r_lat_cnt counts up through INIT (the first INIT edge is
   // the one that loads base_addr) and counts down through EXEC; the edge
   // that sees it at 1 is the one where it reaches 0, so stall drops and
   // the PC updates together on exactly edge N+LAT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= INIT;
         r_lat_cnt   <= '0;
         r_stall     <= 1'b1;
         r_pc        <= '0;
         r_instr_cnt <= '0;
         r_err_cnt   <= '0;
         r_mem       <= '0;
         r_isz_skip  <= 1'b0;
         r_illegal   <= 1'b0;
      end else begin
         case (r_state)
            INIT: begin
               if (r_lat_cnt == '0) begin
                  r_pc <= base_addr;
               end
               if (r_lat_cnt == CW'(INIT_STALL - 1)) begin
                  r_state   <= IDLE;
                  r_stall   <= 1'b0;
                  r_lat_cnt <= '0;
               end else begin
                  r_lat_cnt <= r_lat_cnt + CW'(1);
               end
            end
            IDLE: begin
               if (!w_bubble) begin
                  r_mem       <= pdp_mem_opcode;
                  r_isz_skip  <= isz_skip;
                  r_illegal   <= w_illegal;
                  r_instr_cnt <= r_instr_cnt + 32'd1;
                  if (w_illegal && (r_err_cnt != 16'hFFFF)) begin
                     r_err_cnt <= r_err_cnt + 16'd1;
                  end
                  r_lat_cnt   <= w_lat;
                  r_stall     <= 1'b1;
                  r_state     <= EXEC;
               end
            end
            EXEC: begin
               r_lat_cnt <= r_lat_cnt - CW'(1);
               if (r_lat_cnt == CW'(1)) begin
                  r_stall <= 1'b0;
                  r_state <= IDLE;
                  r_pc    <= w_next_pc;
               end
            end
            default: begin
               r_state <= INIT;
               r_stall <= 1'b1;
            end
         endcase
      end
   end

   assign stall     = r_stall;
   assign PC_value  = r_pc;
   assign instr_cnt = r_instr_cnt;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_instr_exec_responder.sv
// ---------------------------------------------------------------------------
// tb_instr_exec_responder
// Self-checking bench for instr_exec_responder with default parameters
// (MEM_LAT=4, OP7_LAT=2, INIT_STALL=2). Expected results are pushed to a
// scoreboard queue as each opcode is driven and popped when stall drops.
// ---------------------------------------------------------------------------
module tb_instr_exec_responder;
   import pdp8_pkg::*;

   localparam logic [5:0]  M_AND = 6'b100000;
   localparam logic [5:0]  M_TAD = 6'b010000;
   localparam logic [5:0]  M_ISZ = 6'b001000;
   localparam logic [5:0]  M_DCA = 6'b000100;
   localparam logic [5:0]  M_JMS = 6'b000010;
   localparam logic [5:0]  M_JMP = 6'b000001;
   localparam logic [21:0] O_NOP  = 22'd1 << 21;
   localparam logic [21:0] O_IAC  = 22'd1 << 20;
   localparam logic [21:0] O_CLA1 = 22'd1 << 11;

   typedef struct {
      logic [5:0]  mflags;
      logic [11:0] maddr;
      logic [21:0] o7;
      logic        skip;
      logic [11:0] pc;
      int          lat;
      logic [15:0] ecnt;
   } op_t;

   typedef struct {
      logic [11:0] pc;
      int          lat;
      logic [31:0] icnt;
      logic [15:0] ecnt;
   } exp_t;

   logic            clk;
   logic            reset;
   logic [11:0]     base_addr;
   pdp_mem_opcode_s mem_op;
   pdp_op7_opcode_s op7_op;
   logic            isz_skip;
   logic            stall;
   logic [11:0]     PC_value;
   logic [31:0]     instr_cnt;
   logic [15:0]     err_cnt;

   int          checks;
   int          errors;
   logic [31:0] exp_icnt;
   exp_t        sb[$];

   instr_exec_responder dut (
      .clk            (clk),
      .reset          (reset),
      .base_addr      (base_addr),
      .pdp_mem_opcode (mem_op),
      .pdp_op7_opcode (op7_op),
      .isz_skip       (isz_skip),
      .stall          (stall),
      .PC_value       (PC_value),
      .instr_cnt      (instr_cnt),
      .err_cnt        (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one opcode while stall is low, then clear the inputs and count
   // how many sampled cycles stall stays high. isz_skip is inverted after
   // acceptance so the DUT must use its latched copy.
   task automatic run_op(input op_t t, output int cycles);
      mem_op   = pdp_mem_opcode_s'({t.mflags, t.maddr});
      op7_op   = pdp_op7_opcode_s'(t.o7);
      isz_skip = t.skip;
      @(posedge clk); #1;
      mem_op   = '0;
      op7_op   = '0;
      isz_skip = ~t.skip;
      cycles   = 0;
      while (stall === 1'b1 && cycles < 64) begin
         cycles++;
         @(posedge clk); #1;
      end
      isz_skip = 1'b0;
   endtask

   task automatic test_reset();
      base_addr = 12'o0200;
      reset     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks += 4;
      if (stall !== 1'b1) begin errors++; $display("[TB] FAIL reset_stall got %b expected 1", stall); end
      if (PC_value !== 12'o0) begin errors++; $display("[TB] FAIL reset_pc got %o expected 0", PC_value); end
      if (instr_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_icnt got %0d expected 0", instr_cnt); end
      if (err_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_ecnt got %0d expected 0", err_cnt); end
      reset = 1'b0;
      @(posedge clk); #1;
      checks += 2;
      if (stall !== 1'b1) begin errors++; $display("[TB] FAIL init_stall1 got %b expected 1", stall); end
      if (PC_value !== 12'o0200) begin errors++; $display("[TB] FAIL init_pc1 got %o expected 200", PC_value); end
      @(posedge clk); #1;
      checks += 2;
      if (stall !== 1'b0) begin errors++; $display("[TB] FAIL init_stall2 got %b expected 0", stall); end
      if (PC_value !== 12'o0200) begin errors++; $display("[TB] FAIL init_pc2 got %o expected 200", PC_value); end
   endtask

   task automatic test_tad();
      op_t  t[1];
      exp_t e;
      int   cyc;
      t[0] = '{M_TAD, 12'o0050, 22'd0, 1'b0, 12'o0201, 4, 16'd0};
      foreach (t[i]) begin
         exp_icnt++;
         sb.push_back('{t[i].pc, t[i].lat, exp_icnt, t[i].ecnt});
         run_op(t[i], cyc);
         e = sb.pop_front();
         checks += 4;
         if (cyc != e.lat) begin errors++; $display("[TB] FAIL tad[%0d]_lat got %0d expected %0d", i, cyc, e.lat); end
         if (PC_value !== e.pc) begin errors++; $display("[TB] FAIL tad[%0d]_pc got %o expected %o", i, PC_value, e.pc); end
         if (instr_cnt !== e.icnt) begin errors++; $display("[TB] FAIL tad[%0d]_icnt got %0d expected %0d", i, instr_cnt, e.icnt); end
         if (err_cnt !== e.ecnt) begin errors++; $display("[TB] FAIL tad[%0d]_ecnt got %0d expected %0d", i, err_cnt, e.ecnt); end
      end
   endtask

   task automatic test_jmp_jms_wrap();
      op_t  t[3];
      exp_t e;
      int   cyc;
      t[0] = '{M_JMP, 12'o7777, 22'd0,  1'b0, 12'o7777, 4, 16'd0};
      t[1] = '{6'd0,  12'o0000, O_CLA1, 1'b0, 12'o0000, 2, 16'd0};
      t[2] = '{M_JMS, 12'o0100, 22'd0,  1'b0, 12'o0101, 4, 16'd0};
      foreach (t[i]) begin
         exp_icnt++;
         sb.push_back('{t[i].pc, t[i].lat, exp_icnt, t[i].ecnt});
         run_op(t[i], cyc);
         e = sb.pop_front();
         checks += 4;
         if (cyc != e.lat) begin errors++; $display("[TB] FAIL jmp[%0d]_lat got %0d expected %0d", i, cyc, e.lat); end
         if (PC_value !== e.pc) begin errors++; $display("[TB] FAIL jmp[%0d]_pc got %o expected %o", i, PC_value, e.pc); end
         if (instr_cnt !== e.icnt) begin errors++; $display("[TB] FAIL jmp[%0d]_icnt got %0d expected %0d", i, instr_cnt, e.icnt); end
         if (err_cnt !== e.ecnt) begin errors++; $display("[TB] FAIL jmp[%0d]_ecnt got %0d expected %0d", i, err_cnt, e.ecnt); end
      end
   endtask

   task automatic test_isz_skip();
      op_t  t[4];
      exp_t e;
      int   cyc;
      t[0] = '{M_JMP, 12'o0300, 22'd0, 1'b0, 12'o0300, 4, 16'd0};
      t[1] = '{M_ISZ, 12'o0055, 22'd0, 1'b1, 12'o0302, 4, 16'd0};
      t[2] = '{M_JMP, 12'o0300, 22'd0, 1'b0, 12'o0300, 4, 16'd0};
      t[3] = '{M_ISZ, 12'o0055, 22'd0, 1'b0, 12'o0301, 4, 16'd0};
      foreach (t[i]) begin
         exp_icnt++;
         sb.push_back('{t[i].pc, t[i].lat, exp_icnt, t[i].ecnt});
         run_op(t[i], cyc);
         e = sb.pop_front();
         checks += 4;
         if (cyc != e.lat) begin errors++; $display("[TB] FAIL isz[%0d]_lat got %0d expected %0d", i, cyc, e.lat); end
         if (PC_value !== e.pc) begin errors++; $display("[TB] FAIL isz[%0d]_pc got %o expected %o", i, PC_value, e.pc); end
         if (instr_cnt !== e.icnt) begin errors++; $display("[TB] FAIL isz[%0d]_icnt got %0d expected %0d", i, instr_cnt, e.icnt); end
         if (err_cnt !== e.ecnt) begin errors++; $display("[TB] FAIL isz[%0d]_ecnt got %0d expected %0d", i, err_cnt, e.ecnt); end
      end
   endtask

   task automatic test_illegal();
      op_t  t[3];
      exp_t e;
      int   cyc;
      t[0] = '{M_AND | M_TAD, 12'o0010, 22'd0,  1'b0, 12'o0302, 2, 16'd1};
      t[1] = '{M_TAD,         12'o0010, O_IAC,  1'b0, 12'o0303, 2, 16'd2};
      t[2] = '{M_JMP,         12'o7000, O_CLA1, 1'b0, 12'o0304, 2, 16'd3};
      foreach (t[i]) begin
         exp_icnt++;
         sb.push_back('{t[i].pc, t[i].lat, exp_icnt, t[i].ecnt});
         run_op(t[i], cyc);
         e = sb.pop_front();
         checks += 4;
         if (cyc != e.lat) begin errors++; $display("[TB] FAIL ill[%0d]_lat got %0d expected %0d", i, cyc, e.lat); end
         if (PC_value !== e.pc) begin errors++; $display("[TB] FAIL ill[%0d]_pc got %o expected %o", i, PC_value, e.pc); end
         if (instr_cnt !== e.icnt) begin errors++; $display("[TB] FAIL ill[%0d]_icnt got %0d expected %0d", i, instr_cnt, e.icnt); end
         if (err_cnt !== e.ecnt) begin errors++; $display("[TB] FAIL ill[%0d]_ecnt got %0d expected %0d", i, err_cnt, e.ecnt); end
      end
   endtask

   task automatic test_bubble();
      int stalled;
      mem_op  = '0;
      op7_op  = '0;
      stalled = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (stall !== 1'b0) stalled++;
      end
      checks += 4;
      if (stalled != 0) begin errors++; $display("[TB] FAIL bubble_stall got %0d stalled cycles expected 0", stalled); end
      if (PC_value !== 12'o0304) begin errors++; $display("[TB] FAIL bubble_pc got %o expected 304", PC_value); end
      if (instr_cnt !== exp_icnt) begin errors++; $display("[TB] FAIL bubble_icnt got %0d expected %0d", instr_cnt, exp_icnt); end
      if (err_cnt !== 16'd3) begin errors++; $display("[TB] FAIL bubble_ecnt got %0d expected 3", err_cnt); end
   endtask

   // Each opcode is driven the moment stall is seen low, so acceptance
   // must happen on edge N+LAT+1 or the stall count comes back as 0.
   task automatic test_back_to_back();
      op_t  t[3];
      exp_t e;
      int   cyc;
      t[0] = '{6'd0,  12'o0000, O_NOP, 1'b0, 12'o0305, 2, 16'd3};
      t[1] = '{6'd0,  12'o0000, O_NOP, 1'b0, 12'o0306, 2, 16'd3};
      t[2] = '{M_DCA, 12'o0020, 22'd0, 1'b0, 12'o0307, 4, 16'd3};
      foreach (t[i]) begin
         exp_icnt++;
         sb.push_back('{t[i].pc, t[i].lat, exp_icnt, t[i].ecnt});
         run_op(t[i], cyc);
         e = sb.pop_front();
         checks += 4;
         if (cyc != e.lat) begin errors++; $display("[TB] FAIL b2b[%0d]_lat got %0d expected %0d", i, cyc, e.lat); end
         if (PC_value !== e.pc) begin errors++; $display("[TB] FAIL b2b[%0d]_pc got %o expected %o", i, PC_value, e.pc); end
         if (instr_cnt !== e.icnt) begin errors++; $display("[TB] FAIL b2b[%0d]_icnt got %0d expected %0d", i, instr_cnt, e.icnt); end
         if (err_cnt !== e.ecnt) begin errors++; $display("[TB] FAIL b2b[%0d]_ecnt got %0d expected %0d", i, err_cnt, e.ecnt); end
      end
   endtask

   task automatic test_reset_mid_exec();
      base_addr = 12'o0400;
      mem_op    = pdp_mem_opcode_s'({M_TAD, 12'o0123});
      @(posedge clk); #1;
      mem_op = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks += 1;
      if (stall !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_stall got %b expected 1", stall); end
      reset = 1'b1;
      #1;
      checks += 4;
      if (stall !== 1'b1) begin errors++; $display("[TB] FAIL mid_stall got %b expected 1", stall); end
      if (PC_value !== 12'o0) begin errors++; $display("[TB] FAIL mid_pc got %o expected 0", PC_value); end
      if (instr_cnt !== 32'd0) begin errors++; $display("[TB] FAIL mid_icnt got %0d expected 0", instr_cnt); end
      if (err_cnt !== 16'd0) begin errors++; $display("[TB] FAIL mid_ecnt got %0d expected 0", err_cnt); end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks += 2;
      if (stall !== 1'b0) begin errors++; $display("[TB] FAIL mid_rel_stall got %b expected 0", stall); end
      if (PC_value !== 12'o0400) begin errors++; $display("[TB] FAIL mid_rel_pc got %o expected 400", PC_value); end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      exp_icnt  = '0;
      reset     = 1'b1;
      base_addr = 12'o0200;
      mem_op    = '0;
      op7_op    = '0;
      isz_skip  = 1'b0;
      test_reset();
      test_tad();
      test_jmp_jms_wrap();
      test_isz_skip();
      test_illegal();
      test_bubble();
      test_back_to_back();
      test_reset_mid_exec();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/instr_exec_responder.md
# instr_exec_responder

Synthesizable stand-in for the execution unit, used in the unit-level decode testbench. Consumes the decode-to-exec opcode structs, holds `stall` high for an opcode-dependent latency and maintains `PC_value` as the real execution unit would. The fetch/decode unit can therefore be verified without the full datapath. Also counts executed and illegal instructions for scoreboarding.

## Interface
Parameters:
- `MEM_LAT`, default 4: stall cycles for any memory-reference opcode (must be ≥1).
- `OP7_LAT`, default 2: stall cycles for any op7 opcode, including NOP (must be ≥1).
- `INIT_STALL`, default 2: cycles `stall` stays high after reset release before the first opcode is accepted (must be ≥1).

Ports:
- `clk`, input, 1: the single clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `base_addr`, input, `ADDR_WIDTH`: start PC, loaded at reset release.
- `pdp_mem_opcode`, input, `pdp_mem_opcode_s`: memory-reference opcode.
- `pdp_op7_opcode`, input, `pdp_op7_opcode_s`: group-7 operate opcode.
- `isz_skip`, input, 1: bench control; when high at ISZ acceptance, ISZ skips.
- `stall`, output, 1: high means the decode unit must hold its opcodes.
- `PC_value`, output, `ADDR_WIDTH`: current program counter.
- `instr_cnt`, output, 32: accepted non-zero opcodes.
- `err_cnt`, output, 16: accepted illegal opcodes.

## Operation
- States: `INIT`, `IDLE`, `EXEC`.
- Reset values: state `INIT`, `stall`=1, `PC_value`=0, `instr_cnt`=0, `err_cnt`=0, latency counter 0.
- **INIT**
  - First clock after reset release: `PC_value` loads `base_addr`.
  - `stall` stays 1 for `INIT_STALL` cycles, then state goes to `IDLE` with `stall`=0.
- **IDLE** (`stall`=0): opcodes are sampled on every rising edge.
  - Both structs all-zero: bubble. No action, remain in `IDLE`.
  - Otherwise latch both structs and `isz_skip`, increment `instr_cnt`, go to `EXEC`, set `stall`=1.
  - Load the latency counter with `MEM_LAT` if the mem struct is non-zero, else `OP7_LAT`.
- **Illegal opcode**: more than one of the mem flags {AND,TAD,ISZ,DCA,JMS,JMP} set, or mem and op7 both non-zero.
  - Increments `err_cnt`, saturating at 16'hFFFF.
  - Executes as NOP with `OP7_LAT` latency.
- **EXEC**: counter decrements each cycle. On the edge where it reaches 0:
  - `stall` returns to 0 and state returns to `IDLE`.
  - `PC_value` updates on this same edge.
- **PC update**, all arithmetic modulo 2^12 (12'hFFF+1 = 12'h000):
  - AND/TAD/DCA: PC+1.
  - ISZ: PC+2 if latched `isz_skip`, else PC+1.
  - JMP: `mem_inst_addr`.
  - JMS: `mem_inst_addr`+1.
  - op7 (any flag, including NOP) or illegal: PC+1.
- Opcodes presented while `stall`=1 are ignored. A held opcode is re-accepted on the first `IDLE` edge; this is intended, since the decode unit changes opcodes only while `stall`=0.
- **Reset asserted mid-`EXEC`**: all state is cleared immediately and asynchronously, the pending PC update is discarded, and `stall` goes to 1.

## Timing
- Opcode accepted at edge N → `stall`=1 from N until edge N+LAT.
- `stall`=0 and the new `PC_value` are both visible after edge N+LAT.
- Back-to-back instructions: the next opcode can be accepted at edge N+LAT+1, so throughput is one instruction per LAT+1 cycles.
- After reset release: first acceptance no earlier than edge `INIT_STALL`+1.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- `pdp8_pkg` contains:
  - `pdp_mem_opcode_s` (18 bits, MSB first): AND, TAD, ISZ, DCA, JMS, JMP, `mem_inst_addr[11:0]`.
  - `pdp_op7_opcode_s` (22 one-hot flags, NOP at bit 21).
  - `` `ADDR_WIDTH``=12, `` `DATA_WIDTH``=12, `` `START_ADDRESS``.
  - State enum `exec_resp_state_e`.
- One sub-module, `pc_next_calc`: combinational next-PC selection from the latched opcode. The FSM and counters stay in the top module.

## Test plan
- **Reset and init**: `base_addr`=12'o200, reset pulse, then release → `stall`=1 for 2 cycles, then `PC_value`=12'o200 and `stall`=0.
- **TAD**: TAD with addr 12'o050 accepted → `stall` high for exactly 4 cycles, `PC_value`=12'o201, `instr_cnt`=1.
- **JMP/JMS and wrap**:
  - JMP to 12'o7777 → `PC_value`=12'o7777.
  - Then op7 CLA → `PC_value`=0 after 2 stall cycles.
  - JMS to 12'o0100 → `PC_value`=12'o0101.
- **ISZ skip**: ISZ with `isz_skip`=1 from PC 12'o300 → 12'o302. With `isz_skip`=0 → 12'o301.
- **Illegal opcodes**:
  - AND+TAD both set → `err_cnt`=1, PC+1, 2 stall cycles.
  - mem and op7 both non-zero → `err_cnt`=2.
  - All-zero opcode held 10 cycles → no counter or PC change.
- **Reset mid-`EXEC`**: assert `reset` 2 cycles into a `MEM_LAT` stall → outputs go to reset values immediately, the PC update is lost, and after release `PC_value`=`base_addr`.
